// File: rtl/static_id_pkg.sv
// Shared types and address-map helpers for the static ID APB block.
package static_id_pkg;

  localparam int unsigned WORD_W           = 32;
  localparam int unsigned STATUS_VALID_BIT = 0;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_SUM     = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Byte offset of the checksum register, directly after the ID words.
  function automatic int unsigned checksum_offset(input int unsigned num_words);
    return 4 * num_words;
  endfunction

  // Byte offset of the status register, directly after the checksum.
  function automatic int unsigned status_offset(input int unsigned num_words);
    return (4 * num_words) + 4;
  endfunction

endpackage

// File: rtl/static_reg.sv
// Enable-loaded shadow register with asynchronous clear.
module static_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Load on the enable pulse, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/static_id_apb.sv
// Captures tie-off ID words once after reset, sums them, and exposes
// words, checksum and a valid flag as read-only APB3 registers.
module static_id_apb
  import static_id_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = 4,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_WORDS*WORD_W-1:0] static_i,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [ADDR_WIDTH-1:0]       paddr,
  input  logic [WORD_W-1:0]           pwdata,
  output logic [WORD_W-1:0]           prdata,
  output logic                        pready,
  output logic                        pslverr,
  output logic                        id_valid
);

  localparam int unsigned ID_W   = NUM_WORDS * WORD_W;
  localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] CSUM_ADDR = ADDR_WIDTH'(checksum_offset(NUM_WORDS));
  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = ADDR_WIDTH'(status_offset(NUM_WORDS));

  state_e              r_state;
  state_e              w_state_nxt;
  logic                w_capture_en;
  logic                w_sum_en;
  logic                w_done;
  logic [IDX_W-1:0]    r_index;
  logic [WORD_W-1:0]   r_checksum;
  logic                r_id_valid;
  logic [ID_W-1:0]     w_shadow;
  logic [WORD_W-1:0]   w_cur_word;
  logic                w_last;
  logic                w_access;
  logic                w_aligned;
  logic                w_is_word;
  logic                w_is_csum;
  logic                w_is_stat;
  logic [WIDX_W-1:0]   w_word_idx;
  logic [WORD_W-1:0]   w_word_rd;
  logic [WORD_W-1:0]   w_status;
  logic                w_unused_pwdata;

  // Write data has no destination; fold it so it is visibly consumed.
  assign w_unused_pwdata = ^pwdata;

  // Single wide shadow register, loaded on the capture edge only.
  static_reg #(
    .WIDTH (ID_W)
  ) u_shadow (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_capture_en),
    .i_d     (static_i),
    .o_q     (w_shadow)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CAPTURE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: one capture edge, one edge per word, then park in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CAPTURE: w_state_nxt = ST_SUM;
      ST_SUM:     if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_DONE;
      default:    w_state_nxt = ST_CAPTURE;
    endcase
  end

  // FSM outputs: datapath strobes decoded from the current state.
  always_comb begin
    w_capture_en = 1'b0;
    w_sum_en     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_CAPTURE: w_capture_en = 1'b1;
      ST_SUM:     w_sum_en     = 1'b1;
      ST_DONE:    w_done       = 1'b1;
      default:    w_capture_en = 1'b0;
    endcase
  end

  // Shadow word currently addressed by the summing index.
  always_comb begin
    w_cur_word = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (r_index == IDX_W'(i)) begin
        w_cur_word = w_shadow[i*WORD_W +: WORD_W];
      end
    end
  end

  assign w_last = (r_index == IDX_W'(NUM_WORDS - 1));

  // Index, running checksum and valid flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_index    <= '0;
      r_checksum <= '0;
      r_id_valid <= 1'b0;
    end else if (w_capture_en) begin
      r_index    <= '0;
      r_checksum <= '0;
    end else if (w_sum_en) begin
      r_checksum <= r_checksum + w_cur_word;
      r_index    <= r_index + IDX_W'(1);
      if (w_last) begin
        r_id_valid <= 1'b1;
      end
    end
  end

  assign id_valid = r_id_valid;

  // Address decode for the read-only register map.
  assign w_access   = psel & penable;
  assign w_aligned  = (paddr[1:0] == 2'b00);
  assign w_is_word  = w_aligned && (paddr < CSUM_ADDR);
  assign w_is_csum  = (paddr == CSUM_ADDR);
  assign w_is_stat  = (paddr == STAT_ADDR);
  assign w_word_idx = paddr[ADDR_WIDTH-1:2];

  // Read-data selection among shadow words.
  always_comb begin
    w_word_rd = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (w_word_idx == WIDX_W'(i)) begin
        w_word_rd = w_shadow[i*WORD_W +: WORD_W];
      end
    end
  end

  // Status register image.
  always_comb begin
    w_status                   = '0;
    w_status[STATUS_VALID_BIT] = r_id_valid;
  end

  // APB response: idle outside the access phase and while in reset;
  // word/checksum reads stall until the ID has been summed.
  always_comb begin
    pready  = 1'b1;
    pslverr = 1'b0;
    prdata  = '0;
    if (reset_n && w_access) begin
      if (pwrite) begin
        pslverr = 1'b1;
      end else if (w_is_stat) begin
        prdata = w_status;
      end else if (!(w_is_word || w_is_csum)) begin
        pslverr = 1'b1;
      end else if (!w_done) begin
        pready = 1'b0;
      end else if (w_is_csum) begin
        prdata = r_checksum;
      end else begin
        prdata = w_word_rd;
      end
    end
  end

endmodule
